// File: rtl/qkv_stream_issuer.sv
// qkv_fifo2: two-entry FIFO; head is visible the cycle after a push.
// Latency: 1 cycle from push to head. Backpressure: the caller must not push when full without a same-cycle pop.
// Head reads zero while empty so an idle channel presents clean data.
module qkv_fifo2 #(
  parameter type T = logic [31:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  T           push_dat,
  input  logic       pop,
  output logic       vld,
  output T           head,
  output logic [1:0] count
);
  T     mem [2];
  logic wr_ptr;
  logic rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign vld  = (count != 2'd0);
  assign head = vld ? mem[rd_ptr] : '0;
endmodule

// qkv_channel: read engine for one buffer feeding a 2-entry prefetch FIFO.
// Latency: read issued in cycle t is presented in t+2. Backpressure: reads stop
// once buffered plus in-flight entries would exceed two after this cycle's pop.
module qkv_channel #(
  parameter type T     = logic [31:0],
  parameter int  TOTAL = 1,
  parameter int  WRAP  = 1,
  parameter int  AW    = 1,
  parameter int  CW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          run,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  T              rd_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output T              out_dat,
  output logic          cmpl
);
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] acc_cnt;
  logic          in_flight;
  logic          pop;
  logic [1:0]    occ;

  assign pop   = out_vld && out_rdy;
  // occupancy + in_flight - pop < 2, rearranged to avoid an unsigned subtract
  assign rd_en = run && (rd_cnt != CW'(TOTAL)) &&
                 (({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));
  // Looks one handshake ahead so DONE lands the cycle after the final transfer
  assign cmpl  = (acc_cnt == CW'(TOTAL)) || (pop && (acc_cnt == CW'(TOTAL - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      acc_cnt   <= '0;
      rd_addr   <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_en;
      if (clr) begin
        rd_cnt  <= '0;
        acc_cnt <= '0;
        rd_addr <= '0;
      end else begin
        if (rd_en) begin
          rd_cnt  <= rd_cnt + CW'(1);
          rd_addr <= (rd_addr == AW'(WRAP - 1)) ? '0 : rd_addr + AW'(1);
        end
        if (pop) acc_cnt <= acc_cnt + CW'(1);
      end
    end
  end

  qkv_fifo2 #(.T(T)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight),
    .push_dat (rd_data),
    .pop      (pop),
    .vld      (out_vld),
    .head     (out_dat),
    .count    (occ)
  );
endmodule

// qkv_stream_issuer: streams each Q row once and a full K/V pass per Q row.
// Latency: first transfer 3 cycles after start, then one per cycle per channel.
// Backpressure: each channel stalls independently on its own ready.
module qkv_stream_issuer #(
  parameter int  MAX_SEQ_LENGTH = 8,
  parameter int  NUM_Q          = MAX_SEQ_LENGTH,
  parameter int  NUM_KV         = MAX_SEQ_LENGTH,
  parameter int  QA_W           = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
  parameter int  KA_W           = (NUM_KV > 1) ? $clog2(NUM_KV) : 1,
  parameter type Q_VECTOR_T     = logic [31:0],
  parameter type K_VECTOR_T     = logic [31:0],
  parameter type V_VECTOR_T     = logic [31:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            q_rd_en,
  output logic [QA_W-1:0] q_rd_addr,
  input  Q_VECTOR_T       q_rd_data,
  output logic            k_rd_en,
  output logic [KA_W-1:0] k_rd_addr,
  input  K_VECTOR_T       k_rd_data,
  output logic            v_rd_en,
  output logic [KA_W-1:0] v_rd_addr,
  input  V_VECTOR_T       v_rd_data,
  output logic            Q_vld_out,
  input  logic            Q_rdy_in,
  output Q_VECTOR_T       q_out,
  output logic            K_vld_out,
  input  logic            K_rdy_in,
  output K_VECTOR_T       k_out,
  output logic            V_vld_out,
  input  logic            V_rdy_in,
  output V_VECTOR_T       v_out
);
  localparam int KV_TOTAL = NUM_Q * NUM_KV;
  localparam int QC_W     = $clog2(NUM_Q + 1);
  localparam int KC_W     = $clog2(KV_TOTAL + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state, state_nxt;
  logic   run, job_start;
  logic   q_cmpl, k_cmpl, v_cmpl;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    run       = 1'b0;
    job_start = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ST_RUN;
          job_start = 1'b1;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (q_cmpl && k_cmpl && v_cmpl) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  qkv_channel #(.T(Q_VECTOR_T), .TOTAL(NUM_Q), .WRAP(NUM_Q), .AW(QA_W), .CW(QC_W)) u_q (
    .clk (clk), .rst (rst), .clr (job_start), .run (run),
    .rd_en (q_rd_en), .rd_addr (q_rd_addr), .rd_data (q_rd_data),
    .out_vld (Q_vld_out), .out_rdy (Q_rdy_in), .out_dat (q_out), .cmpl (q_cmpl)
  );

  qkv_channel #(.T(K_VECTOR_T), .TOTAL(KV_TOTAL), .WRAP(NUM_KV), .AW(KA_W), .CW(KC_W)) u_k (
    .clk (clk), .rst (rst), .clr (job_start), .run (run),
    .rd_en (k_rd_en), .rd_addr (k_rd_addr), .rd_data (k_rd_data),
    .out_vld (K_vld_out), .out_rdy (K_rdy_in), .out_dat (k_out), .cmpl (k_cmpl)
  );

  qkv_channel #(.T(V_VECTOR_T), .TOTAL(KV_TOTAL), .WRAP(NUM_KV), .AW(KA_W), .CW(KC_W)) u_v (
    .clk (clk), .rst (rst), .clr (job_start), .run (run),
    .rd_en (v_rd_en), .rd_addr (v_rd_addr), .rd_data (v_rd_data),
    .out_vld (V_vld_out), .out_rdy (V_rdy_in), .out_dat (v_out), .cmpl (v_cmpl)
  );
endmodule

// File: doc/qkv_stream_issuer.md
# qkv_stream_issuer

Producer side of the Q/K/V valid/ready handshake consumed by the dot-product stage. On `start` it reads Q, K and V rows from three synchronous-read buffers. It streams Q row *i* once and K/V rows 0..NUM_KV-1 once per Q row, for every Q row. This is exactly the sequence the dot-product stage expects: Q held across a full K/V pass. Each channel is decoupled by a 2-entry prefetch FIFO so that one transfer per cycle per channel is sustained despite the 1-cycle buffer read latency.

## Interface
- `NUM_Q`, default `MAX_SEQ_LENGTH`: number of Q rows per job (≥1).
- `NUM_KV`, default `MAX_SEQ_LENGTH`: K/V rows per pass (≥1); the dot-product stage row count must match.
- `QA_W`, default `$clog2(NUM_Q)` (min 1): Q address width.
- `KA_W`, default `$clog2(NUM_KV)` (min 1): K/V address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: job start; honoured only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at job completion.
- `q_rd_en` out 1, `q_rd_addr` out QA_W: Q buffer read request.
- `q_rd_data` in `Q_VECTOR_T`: valid the cycle after `q_rd_en`.
- `k_rd_en` out 1, `k_rd_addr` out KA_W, `k_rd_data` in `K_VECTOR_T`: same latency rule as Q.
- `v_rd_en` out 1, `v_rd_addr` out KA_W, `v_rd_data` in `V_VECTOR_T`: same latency rule as Q.
- `Q_vld_out` out 1, `Q_rdy_in` in 1, `q_out` out `Q_VECTOR_T`: Q channel.
- `K_vld_out` out 1, `K_rdy_in` in 1, `k_out` out `K_VECTOR_T`: K channel.
- `V_vld_out` out 1, `V_rdy_in` in 1, `v_out` out `V_VECTOR_T`: V channel.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DONE when all three accept counters reach their totals.
  - DONE → IDLE unconditionally after 1 cycle; `done` is high in DONE only.
  - `start` outside IDLE is ignored.
- Three identical, independent channel engines (Q, K, V). Each has:
  - read counter, in-flight flag, 2-entry FIFO (head drives `*_out`, `*_vld_out` = FIFO non-empty), accept counter.
- Read issue, in RUN only: `*_rd_en` = (remaining reads > 0) && (occupancy + in_flight − pop_this_cycle < 2).
  - pop = `*_vld_out && *_rdy_in`.
  - Returned data is written into the FIFO on the cycle it arrives.
- Read totals:
  - Q: NUM_Q reads, addresses 0..NUM_Q-1.
  - K and V: NUM_Q·NUM_KV reads each; address counter 0..NUM_KV-1 wraps to 0 after NUM_KV-1.
  - K and V addresses advance independently.
- Accept counters count handshakes. Completion = Q accepts == NUM_Q && K accepts == V accepts == NUM_Q·NUM_KV.
- Cross-channel ordering is not enforced here; the consumer throttles Q with `Q_rdy_in`. Data order within each channel is strict.
- Output data is held stable while `*_vld_out && !*_rdy_in`. Data is never dropped or duplicated.
- Counter widths: K/V read and accept counters hold NUM_Q·NUM_KV (`$clog2(NUM_Q*NUM_KV+1)` bits). No overflow.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, all `*_rd_en`, all `*_vld_out` = 0.
  - addresses 0; `*_out` = 0.
  - FIFOs empty; in-flight flags and counters cleared.
- Mid-operation reset:
  - Next cycle matches the reset values above.
  - Read data returning after reset is discarded.
  - The next `start` restarts from address 0.
- `start` sampled in IDLE at cycle 0:
  - RUN and first `*_rd_en` (addr 0) at cycle 1.
  - Data captured at end of cycle 2.
  - `*_vld_out` first high at cycle 3.
- With `*_rdy_in` held high, each channel transfers every cycle from cycle 3 until its total is reached (no bubbles).
- Backpressure: at most 2 buffered + 0 in flight, or 1 buffered + 1 in flight. `*_rd_en` stays low while the FIFO is full. Throughput resumes the cycle `*_rdy_in` returns.
- FIFO simultaneous push and pop when full-minus-one or full: legal; occupancy unchanged.
- Last handshake completing all channels at cycle N: DONE (`done`=1) at N+1, IDLE at N+2. `start` is accepted at N+2 at the earliest.
- `*_rd_en` is never asserted in IDLE or DONE.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs. All outputs 0, `busy`=0. `start` during `rst` is ignored.
- Free-flow, NUM_Q=2, NUM_KV=4, all ready=1, buffers preloaded Q[i]=i+1, K[j]=0x10+j, V[j]=0x20+j, start@0:
  - `q_out` 1,2 at cycles 3,4.
  - `k_out` 0x10..0x13,0x10..0x13 at cycles 3..10; `v_out` likewise 0x20...
  - `done` at cycle 11; IDLE at cycle 12.
- Backpressure: same job with `K_rdy_in`=0 cycles 4–9.
  - `k_out`=0x11 held stable through cycle 9.
  - `k_rd_en` low while 2 entries are held.
  - K resumes at 0x11 in cycle 10 with no loss or duplication. V is unaffected.
- Lock-step consumer: model the dot-product consumer (Q accepted only when its row counter is 0, K/V accepted together).
  - Exactly 2 Q and 8 K/V handshakes.
  - Scores match the golden dot products; `done` fires once.
- Reset mid-run: assert `rst` after the 3rd K handshake.
  - Next cycle all `*_vld_out`=0, `busy`=0.
  - Re-`start` replays from Q[0]/K[0]/V[0].
- `start` pulsed during RUN and DONE: ignored. Exactly one job runs and exactly one `done` pulse is produced.
